serial_frame_decoder: RTL

Byte-level frame decoder placed directly downstream of the UART receiver. It consumes the receiver's one-cycle byte strobe and parallel byte. It hunts for a sync byte, then captures command, length, payload and an XOR checksum. Validated frames are presented to the command logic with a valid/ack handshake. Bad frames and stalled frames are flagged and discarded.

---
 rtl/serial_frame_decoder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/serial_frame_decoder.sv
// Byte-level frame decoder behind the UART receiver: hunts for sync, captures
// CMD/LEN/payload, validates an XOR checksum and holds good frames until acked.
module serial_frame_decoder #(
  parameter int unsigned clk_rate       = 100_000_000,
  parameter int unsigned baud_rate      = 9_600,
  parameter int unsigned data_bit_count = 8,
  parameter int unsigned max_payload    = 16,
  parameter logic [data_bit_count-1:0] sync_byte = 8'hA5,
  parameter int unsigned timeout_bytes  = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [data_bit_count-1:0]                i_data,
  input  logic                                     i_valid,
  input  logic                                     i_frame_ack,
  output logic                                     o_frame_valid,
  output logic [data_bit_count-1:0]                o_cmd,
  output logic [$clog2(max_payload+1)-1:0]         o_length,
  output logic [max_payload*data_bit_count-1:0]    o_payload,
  output logic                                     o_busy,
  output logic                                     o_chk_error,
  output logic                                     o_timeout,
  output logic                                     o_overrun
);

  localparam int unsigned W     = data_bit_count;
  localparam int unsigned LW    = $clog2(max_payload + 1);
  localparam int unsigned LIMIT = timeout_bytes * (clk_rate / baud_rate) * (W + 2);
  localparam int unsigned TW    = $clog2(LIMIT + 1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_HOLD
  } state_t;

  state_t          state;
  logic [W-1:0]    checksum;
  logic [LW-1:0]   idx;
  logic [TW-1:0]   timer;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_HUNT;
      checksum      <= '0;
      idx           <= '0;
      timer         <= '0;
      o_frame_valid <= 1'b0;
      o_cmd         <= '0;
      o_length      <= '0;
      o_payload     <= '0;
      o_busy        <= 1'b0;
      o_chk_error   <= 1'b0;
      o_timeout     <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_chk_error <= 1'b0;
      o_timeout   <= 1'b0;
      o_overrun   <= 1'b0;

      case (state)
        S_HUNT: begin
          if (i_valid && i_data == sync_byte) begin
            state     <= S_CMD;
            checksum  <= '0;
            idx       <= '0;
            timer     <= '0;
            o_payload <= '0;
            o_busy    <= 1'b1;
          end
        end

        S_HOLD: begin
          // Bytes in HOLD are always dropped, even in the ack cycle.
          if (i_valid)
            o_overrun <= 1'b1;
          if (i_frame_ack) begin
            state         <= S_HUNT;
            o_frame_valid <= 1'b0;
          end
        end

        default: begin
          // A strobe on the terminal-count cycle takes priority over the timeout.
          if (i_valid) begin
            timer <= '0;
            case (state)
              S_CMD: begin
                o_cmd    <= i_data;
                checksum <= i_data;
                state    <= S_LEN;
              end
              S_LEN: begin
                if (32'(i_data) > max_payload) begin
                  o_chk_error <= 1'b1;
                  o_busy      <= 1'b0;
                  state       <= S_HUNT;
                end else begin
                  o_length <= LW'(i_data);
                  checksum <= checksum ^ i_data;
                  state    <= (i_data == '0) ? S_CHECK : S_PAYLOAD;
                end
              end
              S_PAYLOAD: begin
                o_payload[32'(idx)*W +: W] <= i_data;
                checksum <= checksum ^ i_data;
                idx      <= idx + LW'(1);
                if (idx == o_length - LW'(1))
                  state <= S_CHECK;
              end
              S_CHECK: begin
                o_busy <= 1'b0;
                if (i_data == checksum) begin
                  o_frame_valid <= 1'b1;
                  state         <= S_HOLD;
                end else begin
                  o_chk_error <= 1'b1;
                  state       <= S_HUNT;
                end
              end
              default: state <= S_HUNT;
            endcase
          end else if (timer == TW'(LIMIT - 1)) begin
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
            timer     <= '0;
            state     <= S_HUNT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
      endcase
    end
  end

endmodule
